// File: rtl/counter_pkg.sv
// Shared helpers for the slow-rate counter blocks: prescaler sizing and
// the default clock rate.
package counter_pkg;

   localparam int DEFAULT_CLK_HZ  = 50_000_000;
   localparam int DEFAULT_TICK_HZ = 1;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // Ceiling log2; only ever evaluated at elaboration time.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         bits = bits + 1;
      end
      return bits;
   endfunction

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/param_updown_counter_tick_gen.sv
// Free-running prescaler: TICK is a registered one-cycle enable every
// CLK_HZ/TICK_HZ cycles, first pulse DIV cycles after reset release.
module tick_gen
   import counter_pkg::*;
#(
   parameter int CLK_HZ  = DEFAULT_CLK_HZ,
   parameter int TICK_HZ = DEFAULT_TICK_HZ
) (
   input  logic Clk50MHz,
   input  logic RST,
   output logic TICK
);

   localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
   localparam int PRE_W = clog2(DIV);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("tick_gen: CLK_HZ/TICK_HZ must be at least 2");
      end
   endgenerate

   localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic             wrap_now;

   assign wrap_now = (pre_cnt == LAST);

   // NOTE: state registers use <= so every flop samples pre-edge values.
   always_ff @(posedge Clk50MHz) begin
      if (RST) begin
         pre_cnt <= '0;
         TICK    <= 1'b0;
      end else begin
         TICK <= wrap_now;
         if (wrap_now) pre_cnt <= '0;
         else          pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with run/stop, single-step, clamped parallel load,
// programmable terminal value and wrap or saturate at the boundaries.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int CLK_HZ  = DEFAULT_CLK_HZ,
   parameter int TICK_HZ = DEFAULT_TICK_HZ,
   parameter int WIDTH   = 8,
   parameter int MAX_VAL = 2**WIDTH - 1,
   parameter int WRAP    = 1
) (
   input  logic             Clk50MHz,
   input  logic             RST,
   input  logic             UD,
   input  logic             SS,
   input  logic             STEP,
   input  logic             LD,
   input  logic [WIDTH-1:0] LD_VAL,
   output logic [WIDTH-1:0] CNT_OUT,
   output logic             TICK,
   output logic             TC,
   output logic             HEARTBEAT
);

   generate
      if (MAX_VAL < 1 || longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
         $error("param_updown_counter: MAX_VAL must lie in 1 .. 2**WIDTH-1");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

   tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_tick_gen (
      .Clk50MHz (Clk50MHz),
      .RST      (RST),
      .TICK     (TICK)
   );

   logic [1:0] ud_sync, ss_sync, step_sync;
   logic       step_d;
   logic       ss_s, step_pulse, adv;
   dir_e       dir;

   assign dir        = dir_e'(ud_sync[1]);
   assign ss_s       = ss_sync[1];
   assign step_pulse = step_sync[1] & ~step_d;
   assign adv        = (TICK & ss_s) | (step_pulse & ~ss_s);

   always_ff @(posedge Clk50MHz) begin
      if (RST) begin
         ud_sync   <= '0;
         ss_sync   <= '0;
         step_sync <= '0;
         step_d    <= 1'b0;
      end else begin
         ud_sync   <= {ud_sync[0], UD};
         ss_sync   <= {ss_sync[0], SS};
         step_sync <= {step_sync[0], STEP};
         step_d    <= step_sync[1];
      end
   end

   logic [WIDTH-1:0] load_val, adv_val;
   logic             adv_tc;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      load_val = (LD_VAL > MAX) ? MAX : LD_VAL;
      adv_val  = CNT_OUT;
      adv_tc   = 1'b0;
      if (dir == DIR_UP) begin
         if (CNT_OUT == MAX) begin
            adv_val = (WRAP != 0) ? '0 : MAX;
            adv_tc  = 1'b1;
         end else begin
            adv_val = CNT_OUT + WIDTH'(1);
         end
      end else begin
         if (CNT_OUT == '0) begin
            adv_val = (WRAP != 0) ? MAX : '0;
            adv_tc  = 1'b1;
         end else begin
            adv_val = CNT_OUT - WIDTH'(1);
         end
      end
   end

   // A load always wins over a simultaneous advance, which is dropped.
   always_ff @(posedge Clk50MHz) begin
      if (RST) begin
         CNT_OUT   <= '0;
         TC        <= 1'b0;
         HEARTBEAT <= 1'b0;
      end else begin
         if (TICK) HEARTBEAT <= ~HEARTBEAT;
         if (LD) begin
            CNT_OUT <= load_val;
            TC      <= 1'b0;
         end else if (adv) begin
            CNT_OUT <= adv_val;
            TC      <= adv_tc;
         end else begin
            TC <= 1'b0;
         end
      end
   end

endmodule
